// File: rtl/eeg_chip_dat_rx.sv
// eeg_chip_dat_rx
// Receives DAT_DW-wide beats from the chip pads and packs them little-endian
// into OUT_DW-wide words. Words are buffered in a DEPTH-entry FIFO toward the core.
// A word closes on its last beat position or on an in_lst beat.
// Short words are zero-filled, and out_keep marks the filled beats.
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   in_vld/in_rdy/in_lst/in_cmd/in_dat   pad-side beat stream
//   out_vld/out_rdy/out_dat/out_keep/out_cmd/out_lst   core-side word stream
//   pkt_cnt                       packets received (wraps at 16 bits)
//   cmd_err/err_clr               sticky in-packet command-type change flag and its clear
module eeg_chip_dat_rx #(
    parameter int DAT_DW = 8,
    parameter int OUT_DW = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic                       in_lst,
    input  logic                       in_cmd,
    input  logic [DAT_DW-1:0]          in_dat,
    output logic                       in_rdy,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [OUT_DW-1:0]          out_dat,
    output logic [OUT_DW/DAT_DW-1:0]   out_keep,
    output logic                       out_cmd,
    output logic                       out_lst,
    output logic [15:0]                pkt_cnt,
    output logic                       cmd_err,
    input  logic                       err_clr
);

    localparam int R  = OUT_DW / DAT_DW;
    localparam int BW = $clog2(R);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = OUT_DW + R + 2;

    localparam logic [BW-1:0] LAST_BEAT = BW'(R - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    logic [BW-1:0]     beat_q, beat_d;
    logic [OUT_DW-1:0] acc_q, acc_d;
    logic              first_q, first_d;
    logic              pcmd_q, pcmd_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic [FW-1:0]     mem [DEPTH];

    logic              accept, pop, close;
    logic [OUT_DW-1:0] wdat;
    logic [R-1:0]      wkeep;
    logic              wcmd;
    logic [FW-1:0]     head;

    always_comb begin
        in_rdy  = !rst && (occ_q < DEPTH_C);
        out_vld = !rst && (occ_q != '0);
        accept  = in_vld && in_rdy;
        pop     = out_vld && out_rdy;

        // Merge the incoming beat into the partial word. The accumulator is
        // cleared on close, so the unfilled upper beats read as zero.
        wdat  = acc_q;
        wkeep = '0;
        for (int unsigned k = 0; k < R; k++) begin
            if (beat_q == BW'(k)) wdat[k*DAT_DW +: DAT_DW] = in_dat;
            wkeep[k] = (BW'(k) <= beat_q);
        end
        wcmd  = first_q ? in_cmd : pcmd_q;
        close = accept && (in_lst || (beat_q == LAST_BEAT));

        beat_d  = beat_q;
        acc_d   = acc_q;
        first_d = first_q;
        pcmd_d  = pcmd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        occ_d   = occ_q;

        if (accept) begin
            first_d = in_lst;
            if (first_q) pcmd_d = in_cmd;
            if (close) begin
                beat_d = '0;
                acc_d  = '0;
            end else begin
                beat_d = beat_q + BW'(1);
                acc_d  = wdat;
            end
            if (in_lst) cnt_d = cnt_q + 16'd1;
        end

        // The set condition is checked first so it takes priority over err_clr.
        if (accept && !first_q && (in_cmd != pcmd_q)) err_d = 1'b1;
        else if (err_clr)                              err_d = 1'b0;

        if (close) wp_d = wp_q + AW'(1);
        if (pop)   rp_d = rp_q + AW'(1);
        case ({close, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        head     = mem[rp_q];
        out_dat  = out_vld ? head[OUT_DW-1:0]      : '0;
        out_keep = out_vld ? head[OUT_DW +: R]     : '0;
        out_cmd  = out_vld ? head[OUT_DW + R]      : 1'b0;
        out_lst  = out_vld ? head[OUT_DW + R + 1]  : 1'b0;
        pkt_cnt  = rst ? '0 : cnt_q;
        cmd_err  = rst ? 1'b0 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q  <= '0;
            acc_q   <= '0;
            first_q <= 1'b1;
            pcmd_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
        end else begin
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            pcmd_q  <= pcmd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (close) mem[wp_q] <= {in_lst, wcmd, wkeep, wdat};
    end

endmodule
